housekeeping_spi_slave: RTL

HOUSEKEEPING_SPI_SLAVE -- requirements
Module: housekeeping_spi_slave

---
 rtl/housekeeping_spi_slave.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/housekeeping_spi_slave.sv
// SPI mode-0 housekeeping slave bridging an asynchronous SPI master
// to AXI-Stream byte streams on clk_core, with sticky error flags.
module housekeeping_spi_slave #(
    parameter bit         MSB_FIRST   = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk_core,
    input  logic       clk_core_resn,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       status_clear,
    output logic       status_overrun,
    output logic       status_underrun,
    output logic [15:0] frame_count
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sclk_prev;
    logic                   armed;

    logic [2:0] bit_cnt;
    logic [7:0] rx_sr;
    logic [7:0] tx_sr;
    logic       hold_first;

    logic       sclk_s, csn_s, mosi_s;
    logic       start, stop;
    logic       sclk_rise, sclk_fall;
    logic       byte_done, load;
    logic [7:0] rx_next;
    logic [7:0] tx_shift;
    logic [7:0] tx_load;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // armed only once CSN has been seen high after the reset values flushed
    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            sclk_sync <= '1;
            csn_sync  <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_prev <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            if (fill[SYNC_STAGES-1] && csn_s)
                armed <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (armed && !csn_s) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_s) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end
            end
        endcase
    end

    assign sclk_rise = (state_q == ACTIVE) && !csn_s && sclk_s && !sclk_prev;
    assign sclk_fall = (state_q == ACTIVE) && !csn_s && !sclk_s && sclk_prev;
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign load      = start || byte_done;

    assign rx_next  = MSB_FIRST ? {rx_sr[6:0], mosi_s}
                                : {mosi_s, rx_sr[7:1]};
    assign tx_shift = MSB_FIRST ? {tx_sr[6:0], 1'b0}
                                : {1'b0, tx_sr[7:1]};
    assign tx_load  = s_axis_tvalid ? s_axis_tdata : IDLE_BYTE;

    assign s_axis_tready = clk_core_resn && load && s_axis_tvalid;
    assign spi_miso_oe   = (state_q == ACTIVE);
    assign spi_miso      = spi_miso_oe && (MSB_FIRST ? tx_sr[7] : tx_sr[0]);

    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            state_q         <= IDLE;
            bit_cnt         <= '0;
            rx_sr           <= '0;
            tx_sr           <= '0;
            hold_first      <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            status_overrun  <= 1'b0;
            status_underrun <= 1'b0;
            frame_count     <= '0;
        end else begin
            state_q <= state_d;

            if (start)
                bit_cnt <= '0;
            else if (sclk_rise)
                bit_cnt <= bit_cnt + 3'd1;

            if (sclk_rise)
                rx_sr <= rx_next;

            // a freshly loaded byte keeps its first bit across one falling edge
            if (load)
                tx_sr <= tx_load;
            else if (sclk_fall && !hold_first)
                tx_sr <= tx_shift;

            if (start)
                hold_first <= 1'b0;
            else if (byte_done)
                hold_first <= 1'b1;
            else if (sclk_fall)
                hold_first <= 1'b0;

            if (byte_done && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= rx_next;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (status_clear)
                status_overrun <= 1'b0;
            else if (byte_done && m_axis_tvalid && !m_axis_tready)
                status_overrun <= 1'b1;

            if (status_clear)
                status_underrun <= 1'b0;
            else if (load && !s_axis_tvalid)
                status_underrun <= 1'b1;

            if (stop)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule
